// File: rtl/apb_multi_slave_master.sv
// APB master bridge: one local request at a time, address-decoded one-hot PSEL, wait states, error pulse.
// Optional ACCESS-phase timeout is compiled in when APB_TIMEOUT_EN is defined.
module apb_multi_slave_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         transfer,
  input  logic                         write,
  input  logic                         read,
  input  logic [DATA_W/8-1:0]          WSTRB,
  input  logic [ADDR_W-1:0]            apb_waddr,
  input  logic [ADDR_W-1:0]            apb_raddr,
  input  logic [DATA_W-1:0]            apb_wdata,
  output logic [DATA_W-1:0]            apb_rdata,
  output logic                         ready,
  output logic                         done,
  output logic                         error,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int PAD_N  = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_SLAVES_L = (SEL_W + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]       paddr_q, paddr_d;
  logic [DATA_W-1:0]       pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  // Slave-side vectors padded to a power of two so idx_q can index them directly.
  logic [PAD_N-1:0]        pready_pad;
  logic [PAD_N-1:0]        pslverr_pad;
  logic [DATA_W-1:0]       prdata_pad [PAD_N];
  logic [NUM_SLAVES-1:0]   sel_onehot;

  logic [ADDR_W-1:0]       req_addr;
  logic [SEL_W-1:0]        req_idx;
  logic                    req_ok;
  logic                    slv_ready;
  logic                    slv_err;
  logic [DATA_W-1:0]       slv_rdata;
  logic                    timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < PAD_N; gi++) begin : g_pad
      if (gi < NUM_SLAVES) begin : g_real
        assign pready_pad[gi]  = PREADY[gi];
        assign pslverr_pad[gi] = PSLVERR[gi];
        assign prdata_pad[gi]  = PRDATA[gi*DATA_W +: DATA_W];
      end else begin : g_unused
        assign pready_pad[gi]  = 1'b0;
        assign pslverr_pad[gi] = 1'b0;
        assign prdata_pad[gi]  = '0;
      end
    end
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
      assign sel_onehot[gi] = (req_idx == SEL_W'(gi));
    end
  endgenerate

  assign req_addr  = write ? apb_waddr : apb_raddr;
  assign req_idx   = req_addr[SEL_LSB +: SEL_W];
  assign req_ok    = (read ^ write) && ({1'b0, req_idx} < NUM_SLAVES_L);
  assign slv_ready = pready_pad[idx_q];
  assign slv_err   = pslverr_pad[idx_q];
  assign slv_rdata = prdata_pad[idx_q];

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // wait_cnt_q counts earlier stalled ACCESS cycles; the current one is number wait_cnt_q+1.
  assign timeout_hit = !slv_ready && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if (state_q == ACCESS && !slv_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    idx_d     = idx_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (req_ok) begin
            state_d  = SETUP;
            psel_d   = sel_onehot;
            idx_d    = req_idx;
            pwrite_d = write;
            paddr_d  = req_addr;
            pwdata_d = apb_wdata;
            pstrb_d  = write ? WSTRB : '0;
          end else begin
            // Malformed or undecodable request: fail immediately, bus untouched.
            done_d  = 1'b1;
            error_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (slv_ready) begin
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          done_d    = 1'b1;
          error_d   = slv_err;
          if (!pwrite_q && !slv_err) begin
            rdata_d = slv_rdata;
          end
        end else if (timeout_hit) begin
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          done_d    = 1'b1;
          error_d   = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      psel_q    <= '0;
      idx_q     <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      idx_q     <= idx_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign apb_rdata = rdata_q;

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Directed bench for apb_multi_slave_master with three slaves driven straight from the initial block.
module tb_apb_multi_slave_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NS     = 3;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              transfer, write, read;
  logic [3:0]        WSTRB;
  logic [31:0]       apb_waddr, apb_raddr, apb_wdata;
  logic [31:0]       apb_rdata;
  logic              ready, done, error;
  logic [NS-1:0]     PSEL;
  logic              PENABLE, PWRITE;
  logic [31:0]       PADDR, PWDATA;
  logic [3:0]        PSTRB;
  logic [NS-1:0]     PREADY, PSLVERR;
  logic [NS*32-1:0]  PRDATA;

  int n_checks = 0;
  int n_pass   = 0;

  apb_multi_slave_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NS), .SEL_LSB(12), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write), .read(read),
    .WSTRB(WSTRB), .apb_waddr(apb_waddr), .apb_raddr(apb_raddr), .apb_wdata(apb_wdata),
    .apb_rdata(apb_rdata), .ready(ready), .done(done), .error(error),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    PRESET = 1'b1; transfer = 1'b0; write = 1'b0; read = 1'b0; WSTRB = 4'h0;
    apb_waddr = '0; apb_raddr = '0; apb_wdata = '0;
    PREADY = 3'b111; PSLVERR = 3'b000;
    PRDATA = {32'hDEADBEEF, 32'h22222222, 32'h11111111};

    // Reset state
    tick(); tick();
    chk("rst_ready", ready, 1); chk("rst_done", done, 0); chk("rst_error", error, 0);
    chk("rst_psel", PSEL, 0); chk("rst_penable", PENABLE, 0); chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0); chk("rst_pwdata", PWDATA, 0); chk("rst_pstrb", PSTRB, 0);
    chk("rst_rdata", apb_rdata, 0);
    PRESET = 1'b0;
    tick();
    $display("reset: ready=%0b PSEL=%b", ready, PSEL);

    // T1: zero-wait write to slave 0
    transfer = 1'b1; write = 1'b1; read = 1'b0; apb_waddr = 32'h0000; apb_wdata = 32'hA5; WSTRB = 4'b0001;
    tick();
    transfer = 1'b0; write = 1'b0;
    chk("t1_setup_ready", ready, 0); chk("t1_setup_psel", PSEL, 3'b001); chk("t1_setup_penable", PENABLE, 0);
    chk("t1_setup_pwrite", PWRITE, 1); chk("t1_setup_pstrb", PSTRB, 4'b0001); chk("t1_setup_pwdata", PWDATA, 32'hA5);
    chk("t1_setup_done", done, 0);
    tick();
    chk("t1_access_penable", PENABLE, 1); chk("t1_access_psel", PSEL, 3'b001); chk("t1_access_done", done, 0);
    tick();
    chk("t1_done", done, 1); chk("t1_error", error, 0); chk("t1_ready", ready, 1);
    chk("t1_psel_idle", PSEL, 0); chk("t1_penable_idle", PENABLE, 0); chk("t1_pwdata_held", PWDATA, 32'hA5);
    tick();
    chk("t1_done_pulse", done, 0);
    $display("T1 write 0x0000 <= 0xA5: done=%0b error=%0b", done, error);

    // T2: read slave 2 with three wait states
    PREADY = 3'b011;
    transfer = 1'b1; read = 1'b1; apb_raddr = 32'h2008;
    tick();
    transfer = 1'b0; read = 1'b0;
    chk("t2_psel", PSEL, 3'b100); chk("t2_pstrb", PSTRB, 0); chk("t2_pwrite", PWRITE, 0); chk("t2_paddr", PADDR, 32'h2008);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t2_wait%0d_done", i), done, 0);
      chk($sformatf("t2_wait%0d_penable", i), PENABLE, 1);
    end
    PREADY = 3'b111;
    tick();
    chk("t2_done", done, 1); chk("t2_error", error, 0); chk("t2_rdata", apb_rdata, 32'hDEADBEEF);
    tick();
    $display("T2 read 0x2008: rdata=%h", apb_rdata);

    // T3: slave error on write, then clean read from the same slave
    PSLVERR = 3'b010;
    transfer = 1'b1; write = 1'b1; apb_waddr = 32'h1008; apb_wdata = 32'h12345678; WSTRB = 4'b1111;
    tick();
    transfer = 1'b0; write = 1'b0;
    chk("t3_psel", PSEL, 3'b010);
    tick(); tick();
    chk("t3_done", done, 1); chk("t3_error", error, 1); chk("t3_rdata_kept", apb_rdata, 32'hDEADBEEF);
    tick();
    chk("t3_done_pulse", done, 0); chk("t3_error_pulse", error, 0);
    PSLVERR = 3'b000;
    transfer = 1'b1; read = 1'b1; apb_raddr = 32'h1000;
    tick();
    transfer = 1'b0; read = 1'b0;
    tick(); tick();
    chk("t3_rd_done", done, 1); chk("t3_rd_error", error, 0); chk("t3_rd_rdata", apb_rdata, 32'h22222222);
    tick();
    $display("T3 slverr write then read 0x1000: rdata=%h", apb_rdata);

    // T4: malformed and undecodable requests
    transfer = 1'b1; read = 1'b1; write = 1'b1; apb_raddr = 32'h3000; apb_waddr = 32'h3000;
    tick();
    transfer = 1'b0; read = 1'b0; write = 1'b0;
    chk("t4_rw_done", done, 1); chk("t4_rw_error", error, 1); chk("t4_rw_psel", PSEL, 0);
    chk("t4_rw_ready", ready, 1); chk("t4_rw_paddr_held", PADDR, 32'h1000);
    tick();
    chk("t4_rw_pulse", done, 0);
    transfer = 1'b1; read = 1'b1; apb_raddr = 32'h3000;
    tick();
    transfer = 1'b0; read = 1'b0;
    chk("t4_idx_done", done, 1); chk("t4_idx_error", error, 1); chk("t4_idx_psel", PSEL, 0);
    tick();
    transfer = 1'b1;
    tick();
    transfer = 1'b0;
    chk("t4_none_done", done, 1); chk("t4_none_error", error, 1); chk("t4_none_penable", PENABLE, 0);
    tick();
    $display("T4 decode faults: PSEL=%b", PSEL);

    // T5: slave 0 never ready
    PREADY = 3'b110;
    transfer = 1'b1; write = 1'b1; apb_waddr = 32'h0004; apb_wdata = 32'h55; WSTRB = 4'b0011;
    tick();
    transfer = 1'b0; write = 1'b0;
`ifdef APB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("t5_stall%0d_done", i), done, 0);
    end
    tick();
    chk("t5_to_done", done, 1); chk("t5_to_error", error, 1); chk("t5_to_psel", PSEL, 0);
    chk("t5_to_penable", PENABLE, 0); chk("t5_to_rdata", apb_rdata, 32'h22222222);
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("t5_stall%0d_done", i), done, 0);
    end
    chk("t5_still_penable", PENABLE, 1); chk("t5_still_psel", PSEL, 3'b001);
    PREADY = 3'b111;
    tick();
    chk("t5_late_done", done, 1); chk("t5_late_error", error, 0);
`endif
    PREADY = 3'b111;
    tick();
    $display("T5 stalled write 0x0004: done=%0b error=%0b", done, error);

    // T6: reset in the middle of ACCESS
    PREADY = 3'b000;
    transfer = 1'b1; write = 1'b1; apb_waddr = 32'h2000; apb_wdata = 32'h77; WSTRB = 4'b1111;
    tick();
    transfer = 1'b0; write = 1'b0;
    tick(); tick();
    chk("t6_mid_penable", PENABLE, 1);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("t6_psel", PSEL, 0); chk("t6_penable", PENABLE, 0); chk("t6_ready", ready, 1);
    chk("t6_done", done, 0); chk("t6_paddr", PADDR, 0); chk("t6_pwdata", PWDATA, 0);
    chk("t6_pstrb", PSTRB, 0); chk("t6_pwrite", PWRITE, 0); chk("t6_rdata", apb_rdata, 0);
    PREADY = 3'b111;
    tick();
    chk("t6_no_done", done, 0);
    transfer = 1'b1; write = 1'b1; apb_waddr = 32'h1000; apb_wdata = 32'hCAFEF00D; WSTRB = 4'b1100;
    tick();
    transfer = 1'b0; write = 1'b0;
    chk("t6_new_psel", PSEL, 3'b010);
    tick(); tick();
    chk("t6_new_done", done, 1); chk("t6_new_error", error, 0);
    chk("t6_new_pwdata", PWDATA, 32'hCAFEF00D); chk("t6_new_pstrb", PSTRB, 4'b1100);
    $display("T6 reset mid-access then write 0x1000: done=%0b", done);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
